// File: rtl/key_cond.sv
// Key conditioner: 2-flop sync, per-key debounce, rise detect, per-player one-hot arbitration.
// Press-to-pulse latency DEBOUNCE_CYC+4 edges (+1 when a player-2 press is held); no backpressure.
module key_cond #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] KEY_raw,
  output logic [7:0] KEY_p,
  output logic [7:0] key_db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [7:0]       k;
  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       db_q;
  logic [7:0]       rise;
  logic [CNT_W-1:0] cnt [8];
  logic [3:0]       pend;
  logic             pend_v;
  logic [3:0]       sel1;
  logic [3:0]       sel2;
  logic [3:0]       cand2;

  // Isolate the lowest set bit: v & -v.
  function automatic logic [3:0] lowest(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  assign k = ACTIVE_LOW ? ~KEY_raw : KEY_raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= k;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_db <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == key_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]    <= '0;
          key_db[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rise is registered one edge after key_db goes high, giving the fixed +4 latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_q <= '0;
      rise <= '0;
    end else begin
      db_q <= key_db;
      rise <= key_db & ~db_q;
    end
  end

  assign sel1  = lowest(rise[7:4]);
  assign sel2  = lowest(rise[3:0]);
  assign cand2 = pend_v ? pend : sel2;

  // Player 1 wins the output slot; a competing player-2 event waits one cycle in pend.
  always_ff @(posedge clock) begin
    if (reset) begin
      KEY_p  <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (sel1 != 4'd0) begin
      KEY_p <= {sel1, 4'd0};
      if (cand2 != 4'd0) begin
        pend   <= cand2;
        pend_v <= 1'b1;
      end
    end else begin
      KEY_p <= {4'd0, cand2};
      if (pend_v && (sel2 != 4'd0)) begin
        pend <= sel2;
      end else begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule
